// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative one-bit-per-cycle signed/unsigned multiply and divide for the EX stage
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter logic [5:0] OP_MUL = 6'h18,
  parameter logic [5:0] OP_MULU = 6'h19,
  parameter logic [5:0] OP_DIV = 6'h1A,
  parameter logic [5:0] OP_DIVU = 6'h1B
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [5:0] alu_op,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [3:0] regC_adress_in,
  output logic stall,
  output logic busy,
  output logic done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0] regC_adress_out,
  output logic div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] hi, lo, b, a_mag, b_mag, nhi, nlo;
  logic [WIDTH:0] sum, rs, diff;
  logic [2*WIDTH-1:0] prod;
  logic neg_q, neg_r, dz, valid, sgn, is_div, a_neg, b_neg, last;
  logic [3:0] rc;
  assign valid = alu_op inside {OP_MUL, OP_MULU, OP_DIV, OP_DIVU};
  assign sgn = (alu_op == OP_MUL) || (alu_op == OP_DIV);
  assign is_div = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
  assign a_neg = sgn & regA[WIDTH-1];
  assign b_neg = sgn & regB[WIDTH-1];
  assign a_mag = a_neg ? -regA : regA;
  assign b_mag = b_neg ? -regB : regB;
  assign last = count == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign stall = rst_n & ((state == IDLE & start & valid) | state == MUL | state == DIV);
  // hi/lo is the shift-add accumulator for MUL and the remainder/quotient pair for DIV
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    rs = {hi, lo[WIDTH-1]};
    diff = rs - {1'b0, b};
    nhi = state == MUL ? sum[WIDTH:1] : (diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0]);
    nlo = state == MUL ? {sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ~diff[WIDTH]};
    prod = neg_q ? -{nhi, nlo} : {nhi, nlo};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      hi <= '0;
      lo <= '0;
      b <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      rc <= '0;
      result_lo <= '0;
      result_hi <= '0;
      regC_adress_out <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && valid) begin
          state <= is_div ? DIV : MUL;
          count <= '0;
          b <= b_mag;
          hi <= '0;
          lo <= (is_div && regB == '0) ? regA : a_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dz <= is_div && regB == '0;
          rc <= regC_adress_in;
        end
        MUL, DIV: if (dz) begin
          state <= DONE;
          result_lo <= '1;
          result_hi <= lo;
          div_by_zero <= 1'b1;
          regC_adress_out <= rc;
        end else begin
          hi <= nhi;
          lo <= nlo;
          count <= count + CW'(1);
          if (last) begin
            state <= DONE;
            result_lo <= state == MUL ? prod[WIDTH-1:0] : (neg_q ? -nlo : nlo);
            result_hi <= state == MUL ? prod[2*WIDTH-1:WIDTH] : (neg_r ? -nhi : nhi);
            div_by_zero <= 1'b0;
            regC_adress_out <= rc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
